sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Parametrised single-clock FIFO: storage, pointers, level and status flags in one block.
//  Programmable almost-empty/almost-full thresholds, sticky-free underflow/overflow pulses and an accepted-read counter.
//  Serves as the same-clock buffer stage beside the dual-clock FIFO.
//  Its read side presents the same signal set the read agent already drives and samples.
// PARAMETERS
//  DATA_W  32  word width
//  DEPTH   32  entries; power of 2, >=4
//  ADDR_W  $clog2(DEPTH)  derived; do not override
//  CNT_W   6   fifo_read_count width
// PORTS
//  rclk             in   1         clock, all logic posedge
//  hw_rst_n         in   1         synchronous active-low reset
//  sw_rst           in   1         synchronous active-high soft reset
//  write_enable     in   1         push request
//  write_data       in   DATA_W    push data
//  afull_value      in   ADDR_W+1  almost-full threshold (live)
//  wrfull           out  1         level==DEPTH
//  wr_almost_full   out  1         level>=afull_value
//  overflow         out  1         1-cycle pulse: rejected push
//  read_enable      in   1         pop request
//  aempty_value     in   ADDR_W    almost-empty threshold (live)
//  read_data        out  DATA_W    popped word
//  rdempty          out  1         level==0
//  rd_almost_empty  out  1         level<=aempty_value
//  underflow        out  1         1-cycle pulse: rejected pop
//  fifo_read_count  out  CNT_W     accepted pops since reset, wraps mod 2**CNT_W
//  rd_level         out  ADDR_W+1  current occupancy 0..DEPTH
// BEHAVIOUR
//  Priority per edge: hw_rst_n=0 > sw_rst=1 > push/pop.
//  hw_rst_n: ptrs=0, rd_level=0, read_data=0, count=0.
//   hw_rst_n reset: rdempty=1, rd_almost_empty=1, wrfull=0, wr_almost_full=0, underflow=0, overflow=0.
//  sw_rst: same as hw_rst_n except read_data holds; storage never cleared.
//  Pointers ADDR_W+1 bits (wrap bit); level = wr_ptr-rd_ptr.
//  Push accepted iff write_enable && !wrfull; a pop in the same cycle does NOT free space.
//  Pop accepted iff read_enable && !rdempty; a push in the same cycle does NOT make data poppable.
//  Simultaneous accepted push+pop: level unchanged, both pointers advance.
//  Rejected push -> overflow=1 for exactly the next cycle; ptrs/level unchanged.
//  Rejected pop -> underflow=1 for exactly the next cycle; read_data holds.
//  All flags registered, computed from next-state level: flag change visible on the edge that commits the op.
//  Thresholds compared against next level each cycle; a change affects flags on the following edge.
//  Pointer wrap at DEPTH is modular; full/empty is resolved by the wrap bit.
//  Read latency without FWFT: read_data = mem[rd_ptr] registered on the pop edge (1 cycle); otherwise holds.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined: first-word-fall-through.
//   read_data = mem[rd_ptr] combinationally while !rdempty, 0 while rdempty.
//   read_enable acknowledges the shown word, and the next word appears after that edge.
//  Undefined: standard mode, 1-cycle registered read_data as above.
// STRUCTURE
//  Package sync_fifo_pkg: default DATA_W/DEPTH localparams.
//   Also: function level_calc(wr_ptr, rd_ptr) and typedef fifo_status_t (empty, aempty, full, afull, udf, ovf).
//  Sub-module sync_fifo_mem: 1W/1R register array, write on rclk, async read port; ctrl owns the output register.
// TESTING
//  Reset: any state, hw_rst_n=0 one edge -> rdempty=1, rd_level=0, read_data=0, count=0, flags as reset.
//  Fill/drain: 32 pushes 0..31 -> wrfull=1 after 32nd edge.
//   Then 32 pops -> read_data 0..31 in order, rdempty=1, fifo_read_count=32.
//  Boundaries: full + write_enable -> overflow pulse 1 cycle, rd_level stays 32.
//   Empty + read_enable -> underflow pulse, read_data holds.
//  Simultaneous at empty: push+pop -> pop rejected (underflow=1), rd_level=1.
//   Simultaneous at level 5: push+pop -> level stays 5.
//  Thresholds: aempty_value=3, afull_value=30; level 3->4 clears rd_almost_empty, level 29->30 sets wr_almost_full.
//  Reset mid-op: sw_rst while level=10 -> level 0, rdempty=1, read_data unchanged.
//   Pointer wrap: 3 full fill/drain cycles verify ordering across wrap.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults, status record and level helper for the single-clock FIFO.
// Optional first-word-fall-through read side is selected with SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_CNT_W  = 6;

  typedef struct packed {
    logic empty;
    logic aempty;
    logic full;
    logic afull;
    logic udf;
    logic ovf;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{empty: 1'b1, aempty: 1'b1, default: 1'b0};

  // Occupancy from wrap-bit pointers; modular subtraction resolves full vs empty.
  function automatic int unsigned level_calc(input int unsigned wr_ptr,
                                             input int unsigned rd_ptr,
                                             input int unsigned ptr_w);
    return (wr_ptr - rd_ptr) & ((32'd1 << ptr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// 1W/1R register array: synchronous write, asynchronous read. Contents are never reset.
module sync_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, level, registered status flags and read counter around sync_fifo_mem.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is a 1-cycle registered read.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              rclk,
  input  logic              hw_rst_n,
  input  logic              sw_rst,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W:0]   afull_value,
  output logic              wrfull,
  output logic              wr_almost_full,
  output logic              overflow,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] aempty_value,
  output logic [DATA_W-1:0] read_data,
  output logic              rdempty,
  output logic              rd_almost_empty,
  output logic              underflow,
  output logic [CNT_W-1:0]  fifo_read_count,
  output logic [ADDR_W:0]   rd_level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_status_t      status_q, status_d;
  logic              push_ok, pop_ok;
  logic [DATA_W-1:0] mem_rdata;

  // Acceptance uses the committed level only: a same-cycle pop frees no space
  // and a same-cycle push makes nothing poppable.
  assign push_ok = write_enable && (level_q != FULL_LVL);
  assign pop_ok  = read_enable  && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_ok};
    level_d  = (ADDR_W+1)'(level_calc(32'(wr_ptr_d), 32'(rd_ptr_d), ADDR_W + 1));
    count_d  = count_q + {{(CNT_W-1){1'b0}}, pop_ok};
    status_d        = STATUS_RST;
    status_d.empty  = (level_d == '0);
    status_d.aempty = (level_d <= {1'b0, aempty_value});
    status_d.full   = (level_d == FULL_LVL);
    status_d.afull  = (level_d >= afull_value);
    status_d.udf    = read_enable  && !pop_ok;
    status_d.ovf    = write_enable && !push_ok;
  end

  always_ff @(posedge rclk) begin
    if (!hw_rst_n || sw_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
      status_q <= STATUS_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (rclk),
    .we_i    (push_ok && hw_rst_n && !sw_rst),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (write_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign read_data = status_q.empty ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] read_data_q;

  // Soft reset keeps the last popped word visible.
  always_ff @(posedge rclk) begin
    if (!hw_rst_n) begin
      read_data_q <= '0;
    end else if (!sw_rst && pop_ok) begin
      read_data_q <= mem_rdata;
    end
  end

  assign read_data = read_data_q;
`endif

  assign wrfull          = status_q.full;
  assign wr_almost_full  = status_q.afull;
  assign overflow        = status_q.ovf;
  assign rdempty         = status_q.empty;
  assign rd_almost_empty = status_q.aempty;
  assign underflow       = status_q.udf;
  assign fifo_read_count = count_q;
  assign rd_level        = level_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: reset, fill/drain, flags, boundaries, soft reset and wrap.
module tb_sync_fifo_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  logic              rclk = 1'b0;
  logic              hw_rst_n, sw_rst;
  logic              write_enable, read_enable;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W:0]   afull_value;
  logic [ADDR_W-1:0] aempty_value;
  logic              wrfull, wr_almost_full, overflow;
  logic [DATA_W-1:0] read_data;
  logic              rdempty, rd_almost_empty, underflow;
  logic [CNT_W-1:0]  fifo_read_count;
  logic [ADDR_W:0]   rd_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 rclk = ~rclk;

  sync_fifo_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .rclk            (rclk),
    .hw_rst_n        (hw_rst_n),
    .sw_rst          (sw_rst),
    .write_enable    (write_enable),
    .write_data      (write_data),
    .afull_value     (afull_value),
    .wrfull          (wrfull),
    .wr_almost_full  (wr_almost_full),
    .overflow        (overflow),
    .read_enable     (read_enable),
    .aempty_value    (aempty_value),
    .read_data       (read_data),
    .rdempty         (rdempty),
    .rd_almost_empty (rd_almost_empty),
    .underflow       (underflow),
    .fifo_read_count (fifo_read_count),
    .rd_level        (rd_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    write_enable = 1'b1;
    write_data   = d;
    step();
    write_enable = 1'b0;
  endtask

  task automatic pop_chk(input logic [31:0] exp, input string tag);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, read_data, exp);
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
`else
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    chk(tag, read_data, exp);
`endif
  endtask

  initial begin
    hw_rst_n     = 1'b0;
    sw_rst       = 1'b0;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    write_data   = 32'hdead_beef;
    afull_value  = 6'd30;
    aempty_value = 5'd3;

    // Reset with junk requests present
    step();
    hw_rst_n     = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    chk("rst_empty",  32'(rdempty), 32'd1);
    chk("rst_level",  32'(rd_level), 32'd0);
    chk("rst_rdata",  read_data, 32'd0);
    chk("rst_count",  32'(fifo_read_count), 32'd0);
    chk("rst_full",   32'(wrfull), 32'd0);
    chk("rst_afull",  32'(wr_almost_full), 32'd0);
    chk("rst_aempty", 32'(rd_almost_empty), 32'd1);
    chk("rst_udf",    32'(underflow), 32'd0);
    chk("rst_ovf",    32'(overflow), 32'd0);

    // Fill 0..31 with threshold crossings
    for (int i = 0; i < 32; i++) begin
      push(32'(i));
      if (i == 0)  chk("fill1_empty", 32'(rdempty), 32'd0);
      if (i == 2)  chk("lvl3_aempty", 32'(rd_almost_empty), 32'd1);
      if (i == 3)  chk("lvl4_aempty", 32'(rd_almost_empty), 32'd0);
      if (i == 28) chk("lvl29_afull", 32'(wr_almost_full), 32'd0);
      if (i == 29) chk("lvl30_afull", 32'(wr_almost_full), 32'd1);
      if (i == 30) chk("lvl31_full",  32'(wrfull), 32'd0);
    end
    chk("fill_full",  32'(wrfull), 32'd1);
    chk("fill_level", 32'(rd_level), 32'd32);

    // Overflow at full
    push(32'h5555_5555);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(rd_level), 32'd32);
    step();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain in order
    for (int i = 0; i < 32; i++) begin
      pop_chk(32'(i), "drain_data");
      if (i == 0) chk("drain1_full", 32'(wrfull), 32'd0);
    end
    chk("drain_empty", 32'(rdempty), 32'd1);
    chk("drain_count", 32'(fifo_read_count), 32'd32);

    // Underflow at empty
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    chk("udf_pulse", 32'(underflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("udf_rdata", read_data, 32'd0);
`else
    chk("udf_rdata", read_data, 32'd31);
`endif
    step();
    chk("udf_clear", 32'(underflow), 32'd0);

    // Push+pop at empty: only the push lands
    write_enable = 1'b1;
    read_enable  = 1'b1;
    write_data   = 32'd100;
    step();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    chk("sim0_udf",   32'(underflow), 32'd1);
    chk("sim0_level", 32'(rd_level), 32'd1);
    chk("sim0_count", 32'(fifo_read_count), 32'd32);

    // Push+pop at level 5: level holds
    for (int i = 1; i <= 4; i++) push(32'(100 + i));
    chk("lvl5", 32'(rd_level), 32'd5);
`ifdef SYNC_FIFO_FWFT_EN
    chk("sim5_rdata", read_data, 32'd100);
`endif
    write_enable = 1'b1;
    read_enable  = 1'b1;
    write_data   = 32'd105;
    step();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    chk("sim5_level", 32'(rd_level), 32'd5);
`ifndef SYNC_FIFO_FWFT_EN
    chk("sim5_rdata", read_data, 32'd100);
`endif
    chk("sim5_count", 32'(fifo_read_count), 32'd33);

    // Soft reset at level 10
    for (int i = 6; i <= 10; i++) push(32'(100 + i));
    chk("lvl10", 32'(rd_level), 32'd10);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("sw_level", 32'(rd_level), 32'd0);
    chk("sw_empty", 32'(rdempty), 32'd1);
    chk("sw_count", 32'(fifo_read_count), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("sw_rdata", read_data, 32'd0);
`else
    chk("sw_rdata", read_data, 32'd100);
`endif

    // Offset the pointers, then three full fill/drain passes across the wrap
    for (int i = 0; i < 7; i++) push(32'h700 + 32'(i));
    for (int i = 0; i < 7; i++) pop_chk(32'h700 + 32'(i), "offs_data");
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 32; i++) push(32'((p + 1) << 16) + 32'(i));
      chk("wrap_full", 32'(wrfull), 32'd1);
      for (int i = 0; i < 32; i++) pop_chk(32'((p + 1) << 16) + 32'(i), "wrap_data");
      chk("wrap_empty", 32'(rdempty), 32'd1);
    end
    chk("wrap_count", 32'(fifo_read_count), 32'd39);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
